// File: rtl/wired_fetch_target_queue.sv
//==============================================================================
// wired_fetch_target_queue: fetch target queue; fast predictions are confirmed or
// corrected by the precise predictor one cycle after they are accepted.
// Optional WIRED_FTQ_PERF_EN adds a saturating mismatch counter. Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module wired_fetch_target_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pfast_valid_i,
  input  logic [31:0]              pfast_pc_i,
  input  logic [31:0]              pfast_npc_i,
  input  logic                     pacc_valid_i,
  input  logic [31:0]              pacc_npc_i,
  output logic                     ftq_ready_o,
  output logic                     redir_valid_o,
  output logic [31:0]              redir_pc_o,
  output logic                     fetch_valid_o,
  input  logic                     fetch_ready_i,
  output logic [31:0]              fetch_pc_o,
  output logic [31:0]              fetch_npc_o,
  output logic [$clog2(DEPTH)-1:0] fetch_idx_o,
  input  logic                     flush_i,
  output logic [31:0]              perf_mispred_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     head_q, head_d, tail_q, tail_d;
  logic [31:0]     pc_q  [DEPTH];
  logic [31:0]     pc_d  [DEPTH];
  logic [31:0]     npc_q [DEPTH];
  logic [31:0]     npc_d [DEPTH];
  logic [DEPTH-1:0] conf_q, conf_d;
  logic            pend_q, pend_d;
  logic [AW-1:0]   pend_idx_q, pend_idx_d;

  logic [AW-1:0]   head_idx, tail_idx;
  logic            full, empty, mismatch, enq, deq;

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];
  assign full     = (head_q[AW] != tail_q[AW]) && (head_idx == tail_idx);
  assign empty    = (head_q == tail_q);

  // A precise prediction only matters against the entry accepted last cycle.
  assign mismatch = pacc_valid_i && pend_q && !flush_i &&
                    (pacc_npc_i != npc_q[pend_idx_q]);

  assign ftq_ready_o   = !full;
  assign redir_valid_o = mismatch;
  assign redir_pc_o    = pacc_npc_i;

  assign enq = pfast_valid_i && ftq_ready_o && !mismatch && !flush_i;
  assign deq = fetch_valid_o && fetch_ready_i && !flush_i;

  assign fetch_valid_o = !empty && conf_q[head_idx];
  assign fetch_pc_o    = pc_q[head_idx];
  assign fetch_npc_o   = npc_q[head_idx];
  assign fetch_idx_o   = head_idx;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    conf_d     = conf_q;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      conf_d = '0;
    end else begin
      // Pending entry resolves this cycle whether or not a precise result came.
      if (pend_q) begin
        conf_d[pend_idx_q] = 1'b1;
        if (mismatch) npc_d[pend_idx_q] = pacc_npc_i;
      end
      if (enq) begin
        pc_d[tail_idx]   = pfast_pc_i;
        npc_d[tail_idx]  = pfast_npc_i;
        conf_d[tail_idx] = 1'b0;
        tail_d           = tail_q + 1'b1;
        pend_d           = 1'b1;
        pend_idx_d       = tail_idx;
      end
      if (deq) head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      conf_q     <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      conf_q     <= conf_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
    end
  end

  // Payload storage carries no reset; validity is governed by pointers/confirm bits.
  always_ff @(posedge clk) begin
    pc_q  <= pc_d;
    npc_q <= npc_d;
  end

`ifdef WIRED_FTQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (mismatch && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_mispred_o = perf_q;
`else
  assign perf_mispred_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wired_fetch_target_queue.sv
// tb_wired_fetch_target_queue: directed stimulus with a scoreboard of expected
// fetch entries, checked by an independent monitor on the falling edge.
`timescale 1ns/1ps
`default_nettype none

module tb_wired_fetch_target_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk, rst_n;
  logic          pfast_valid_i, pacc_valid_i, fetch_ready_i, flush_i;
  logic [31:0]   pfast_pc_i, pfast_npc_i, pacc_npc_i;
  logic          ftq_ready_o, redir_valid_o, fetch_valid_o;
  logic [31:0]   redir_pc_o, fetch_pc_o, fetch_npc_o, perf_mispred_o;
  logic [AW-1:0] fetch_idx_o;

  wired_fetch_target_queue #(.DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pfast_valid_i  (pfast_valid_i),
    .pfast_pc_i     (pfast_pc_i),
    .pfast_npc_i    (pfast_npc_i),
    .pacc_valid_i   (pacc_valid_i),
    .pacc_npc_i     (pacc_npc_i),
    .ftq_ready_o    (ftq_ready_o),
    .redir_valid_o  (redir_valid_o),
    .redir_pc_o     (redir_pc_o),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_pc_o     (fetch_pc_o),
    .fetch_npc_o    (fetch_npc_o),
    .fetch_idx_o    (fetch_idx_o),
    .flush_i        (flush_i),
    .perf_mispred_o (perf_mispred_o)
  );

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   npc;
    logic [AW-1:0] idx;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [AW-1:0] slot;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            exp_perf = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic [31:0] perf_exp();
`ifdef WIRED_FTQ_PERF_EN
    return 32'(exp_perf);
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] npc);
    exp_t e;
    e.pc  = pc;
    e.npc = npc;
    e.idx = slot;
    sb.push_back(e);
    slot = slot + 1'b1;
  endtask

  task automatic fast(input logic [31:0] pc, input logic [31:0] npc);
    pfast_valid_i = 1'b1;
    pfast_pc_i    = pc;
    pfast_npc_i   = npc;
  endtask

  task automatic drain();
    fetch_ready_i = 1'b1;
    for (int i = 0; i < 64 && sb.size() != 0; i++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
    tick();
    chk("drain_idle_valid", 32'(fetch_valid_o), 32'd0);
    fetch_ready_i = 1'b0;
  endtask

  // Monitor: every accepted fetch must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && !flush_i && fetch_valid_o && fetch_ready_i) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL fetch_unexpected: got pc 0x%08h npc 0x%08h, expected no entry",
                 fetch_pc_o, fetch_npc_o);
      end else begin
        mon_e = sb.pop_front();
        chk("fetch_pc", fetch_pc_o, mon_e.pc);
        chk("fetch_npc", fetch_npc_o, mon_e.npc);
        chk("fetch_idx", 32'(fetch_idx_o), 32'(mon_e.idx));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; flush_i = 1'b0; fetch_ready_i = 1'b0;
    pfast_valid_i = 1'b0; pfast_pc_i = '0; pfast_npc_i = '0;
    pacc_valid_i = 1'b0; pacc_npc_i = '0; slot = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(ftq_ready_o), 32'd1);
    chk("rst_fetch_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_redir", 32'(redir_valid_o), 32'd0);
    chk("rst_perf", perf_mispred_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Two-cycle latency with no precise prediction, then hold while stalled.
    fast(32'h1000, 32'h1020); push_exp(32'h1000, 32'h1020);
    tick(); pfast_valid_i = 1'b0;
    chk("lat1_valid", 32'(fetch_valid_o), 32'd0);
    tick();
    chk("lat2_valid", 32'(fetch_valid_o), 32'd1);
    chk("lat2_pc", fetch_pc_o, 32'h1000);
    chk("lat2_npc", fetch_npc_o, 32'h1020);
    tick();
    chk("stall_pc", fetch_pc_o, 32'h1000);
    drain();

    // Mismatch: redirect, drop same-cycle fast, overwrite npc.
    fast(32'h1000, 32'h1020);
    tick();
    fast(32'h1020, 32'h1040);
    pacc_valid_i = 1'b1; pacc_npc_i = 32'h2000;
    #1;
    chk("mis_redir_valid", 32'(redir_valid_o), 32'd1);
    chk("mis_redir_pc", redir_pc_o, 32'h2000);
    push_exp(32'h1000, 32'h2000);
    exp_perf++;
    tick(); pfast_valid_i = 1'b0; pacc_valid_i = 1'b0;
    chk("mis_redir_clear", 32'(redir_valid_o), 32'd0);
    chk("mis_perf", perf_mispred_o, perf_exp());
    drain();

    // Matching precise prediction with a new fast enqueue in the same cycle.
    fast(32'h4000, 32'h4100); push_exp(32'h4000, 32'h4100);
    tick();
    fast(32'h4100, 32'h4200); push_exp(32'h4100, 32'h4200);
    pacc_valid_i = 1'b1; pacc_npc_i = 32'h4100;
    #1;
    chk("match_redir", 32'(redir_valid_o), 32'd0);
    tick(); pfast_valid_i = 1'b0; pacc_valid_i = 1'b0;
    tick();
    // Precise prediction with nothing pending is ignored.
    pacc_valid_i = 1'b1; pacc_npc_i = 32'hDEAD_0000;
    #1;
    chk("nopend_redir", 32'(redir_valid_o), 32'd0);
    tick(); pacc_valid_i = 1'b0;
    drain();

    // Fill to DEPTH, blocked extra enqueue, one dequeue reopens ready.
    fetch_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      fast(32'h100 * (i + 1), 32'h100 * (i + 2));
      push_exp(32'h100 * (i + 1), 32'h100 * (i + 2));
      tick();
      if (i == DEPTH - 2) chk("fill_ready_7", 32'(ftq_ready_o), 32'd1);
    end
    chk("full_ready", 32'(ftq_ready_o), 32'd0);
    fast(32'h0BAD, 32'h0BAD);
    tick(); pfast_valid_i = 1'b0;
    chk("full_ready_hold", 32'(ftq_ready_o), 32'd0);
    chk("full_head_pc", fetch_pc_o, 32'h100);
    fetch_ready_i = 1'b1;
    tick(); fetch_ready_i = 1'b0;
    chk("deq_ready", 32'(ftq_ready_o), 32'd1);
    drain();

    // Flush beats enqueue, dequeue and mismatch in the same cycle.
    for (int i = 0; i < 5; i++) begin
      fast(32'h5000 + 32'h10 * i, 32'h5010 + 32'h10 * i);
      push_exp(32'h5000 + 32'h10 * i, 32'h5010 + 32'h10 * i);
      tick();
    end
    flush_i = 1'b1; fetch_ready_i = 1'b1;
    fast(32'h5100, 32'h5110);
    pacc_valid_i = 1'b1; pacc_npc_i = 32'h9999;
    #1;
    chk("flush_redir", 32'(redir_valid_o), 32'd0);
    tick();
    flush_i = 1'b0; fetch_ready_i = 1'b0; pfast_valid_i = 1'b0; pacc_valid_i = 1'b0;
    sb.delete(); slot = '0;
    chk("flush_valid", 32'(fetch_valid_o), 32'd0);
    chk("flush_ready", 32'(ftq_ready_o), 32'd1);
    chk("flush_perf", perf_mispred_o, perf_exp());
    tick(); tick();
    chk("flush_stay_empty", 32'(fetch_valid_o), 32'd0);

    // Back-to-back streaming through several pointer wraps.
    fetch_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      fast(32'h8000 + 32'h20 * i, 32'h8020 + 32'h20 * i);
      push_exp(32'h8000 + 32'h20 * i, 32'h8020 + 32'h20 * i);
      tick();
    end
    pfast_valid_i = 1'b0;
    drain();

    // Asynchronous reset mid-stream, with a mismatch in flight.
    for (int i = 0; i < 4; i++) begin
      fast(32'hA000 + 32'h40 * i, 32'hA040 + 32'h40 * i);
      tick();
    end
    pacc_valid_i = 1'b1; pacc_npc_i = 32'h1;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ftq_ready_o), 32'd1);
    chk("arst_valid", 32'(fetch_valid_o), 32'd0);
    chk("arst_redir", 32'(redir_valid_o), 32'd0);
    chk("arst_perf", perf_mispred_o, 32'd0);
    sb.delete(); slot = '0; exp_perf = 0;
    pacc_valid_i = 1'b0; pfast_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    fast(32'hC000, 32'hC040); push_exp(32'hC000, 32'hC040);
    fetch_ready_i = 1'b1;
    tick(); pfast_valid_i = 1'b0;
    drain();

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wired_fetch_target_queue.md
WIRED_FETCH_TARGET_QUEUE -- requirements
Module: wired_fetch_target_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: queue entries, power of two, 4..32.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port pfast_valid_i  input  1  fast prediction valid.
REQ-005 SHALL have port pfast_pc_i  input  32  fetch-block start PC.
REQ-006 SHALL have port pfast_npc_i  input  32  fast predicted next-block PC.
REQ-007 SHALL have port pacc_valid_i  input  1  precise prediction valid; refers to the fast prediction accepted the previous cycle.
REQ-008 SHALL have port pacc_npc_i  input  32  precise predicted next-block PC.
REQ-009 SHALL have port ftq_ready_o  output  1  fast prediction accepted this cycle; drives the predictor request ready.
REQ-010 SHALL have port redir_valid_o  output  1  precise/fast mismatch, restart prediction.
REQ-011 SHALL have port redir_pc_o  output  32  restart PC.
REQ-012 SHALL have port fetch_valid_o  output  1  head entry available.
REQ-013 SHALL have port fetch_ready_i  input  1  fetch consumes head.
REQ-014 SHALL have port fetch_pc_o  output  32  head block PC.
REQ-015 SHALL have port fetch_npc_o  output  32  head next-block PC.
REQ-016 SHALL have port fetch_idx_o  output  log2(DEPTH)  head entry index.
REQ-017 SHALL have port flush_i  input  1  backend flush, discards all entries.
REQ-018 SHALL have port perf_mispred_o  output  32  fast/precise mismatch count.

Function
REQ-019 SHALL hold DEPTH entries {pc, npc, confirmed} in circular order with head/tail pointers one bit wider than the index; full when pointers differ only in MSB, empty when equal.
REQ-020 SHALL drive ftq_ready_o = not full; enqueue at tail when pfast_valid_i && ftq_ready_o, entry confirmed=0.
REQ-021 SHALL track one pending entry: the one enqueued in the previous cycle.
REQ-022 SHALL, when pacc_valid_i and a pending entry exists and pacc_npc_i == its npc, set confirmed=1.
REQ-023 SHALL, on mismatch, overwrite pending npc with pacc_npc_i, set confirmed=1, drop any same-cycle fast enqueue, and assert redir_valid_o with redir_pc_o = pacc_npc_i combinationally that cycle.
REQ-024 SHALL, when no pacc_valid_i arrives in the cycle after enqueue, set the pending entry confirmed=1 (fast prediction accepted as final).
REQ-025 SHALL ignore pacc_valid_i when no entry is pending; redir_valid_o stays 0.
REQ-026 SHALL drive fetch_valid_o = not empty && head.confirmed; minimum latency enqueue to fetch_valid_o is 2 cycles.
REQ-027 SHALL advance head on fetch_valid_o && fetch_ready_i; fetch outputs are stable while fetch_valid_o && !fetch_ready_i.
REQ-028 SHALL allow same-cycle enqueue and dequeue when full: no, since ready depends on full only; when not full both occur and count is unchanged.
REQ-029 SHALL on flush_i: head=tail=0, pending cleared, redir_valid_o forced 0, same-cycle enqueue and dequeue discarded; flush has priority over all events.
REQ-030 SHALL wrap pointers modulo 2*DEPTH without bubbles.

Reset
REQ-031 SHALL on rst_n low asynchronously clear head, tail, pending, confirmed bits and perf counter; ftq_ready_o=1, fetch_valid_o=0, redir_valid_o=0, perf_mispred_o=0, fetch_pc_o/npc_o don't-care.
REQ-032 SHALL treat reset mid-operation as loss of all entries; first enqueue allowed in the first cycle after deassertion.

Configuration
REQ-033 SHALL, with WIRED_FTQ_PERF_EN defined, increment a 32-bit saturating counter on each REQ-023 mismatch (not during flush); without it, perf_mispred_o is constant 0 and no counter flops exist.

Verification
REQ-034 Enqueue pc=0x1000 npc=0x1020, no pacc -> fetch_valid_o=1 two cycles later with pc 0x1000, npc 0x1020.
REQ-035 Enqueue npc=0x1020, next cycle pacc npc=0x2000 with new fast pc=0x1020 -> redir_valid_o=1, redir_pc_o=0x2000, 0x1020 not enqueued, head npc=0x2000, perf_mispred_o=1 with macro.
REQ-036 DEPTH=8, fetch_ready_i=0, 8 enqueues -> ftq_ready_o=0 after 8th; one dequeue -> ftq_ready_o=1 next cycle.
REQ-037 Queue with 5 entries, flush_i with pfast_valid_i and pacc mismatch same cycle -> empty next cycle, redir_valid_o=0, no count increment.
REQ-038 20 enqueue/dequeue streaming with DEPTH=4 -> in-order pc output, pointer wrap correct, no lost entries.
REQ-039 Assert rst_n low mid-stream -> all outputs to reset values immediately, no clock required.
